// File: rtl/kernel_top_offset_buff_ctrl.sv
// Sequencer for an offset delay-line buffer: fill, steady-state, then zero-injected drain; OFFBUF_CTRL_STALL_CNT_EN adds stall_cnt.
// Latency: first emit the cycle after the SIZE-th accept; state/counters registered, handshakes combinational.
// Backpressure: oready_in low stalls the buffer and upstream together; no element is dropped or repeated.
module kernel_top_offset_buff_ctrl #(
    parameter int SIZE  = 2,
    parameter int NELEM = 64,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ivalid_in,
    output logic            iready_out,
    input  logic            oready_in,
    output logic            ovalid_out,
    output logic            buf_shift,
    output logic            buf_drain,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] in_cnt,
    output logic [CNTW-1:0] out_cnt
`ifdef OFFBUF_CTRL_STALL_CNT_EN
    ,
    output logic [CNTW-1:0] stall_cnt
`endif
);

    if (SIZE < 1) begin : g_bad_size
        $error("kernel_top_offset_buff_ctrl: SIZE must be at least 1");
    end
    if (NELEM <= SIZE) begin : g_bad_nelem
        $error("kernel_top_offset_buff_ctrl: NELEM must exceed SIZE");
    end
    if (CNTW < 31 && (32'd1 << CNTW) <= NELEM) begin : g_bad_cntw
        $error("kernel_top_offset_buff_ctrl: CNTW too narrow for NELEM");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNTW-1:0] SIZE_C  = CNTW'(SIZE);
    localparam logic [CNTW-1:0] NELEM_C = CNTW'(NELEM);
    localparam logic [CNTW-1:0] ONE     = CNTW'(1);

    state_t          state, state_nxt;
    logic [CNTW-1:0] in_cnt_nxt, out_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_cnt_nxt  = in_cnt;
        out_cnt_nxt = out_cnt;
        iready_out  = 1'b0;
        ovalid_out  = 1'b0;
        buf_shift   = 1'b0;
        buf_drain   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt   = S_FILL;
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                end
            end
            S_FILL: begin
                iready_out = 1'b1;
                buf_shift  = ivalid_in;
                if (ivalid_in) begin
                    in_cnt_nxt = in_cnt + ONE;
                    if (in_cnt_nxt == SIZE_C) begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Accept and emit coincide: each shift pushes one in and pops one out.
                iready_out = oready_in;
                ovalid_out = ivalid_in;
                buf_shift  = ivalid_in & oready_in;
                if (ivalid_in && oready_in) begin
                    in_cnt_nxt  = in_cnt + ONE;
                    out_cnt_nxt = out_cnt + ONE;
                    if (in_cnt_nxt == NELEM_C) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                ovalid_out = 1'b1;
                buf_shift  = oready_in;
                buf_drain  = 1'b1;
                if (oready_in) begin
                    out_cnt_nxt = out_cnt + ONE;
                    if (out_cnt_nxt == NELEM_C) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Keep handshakes quiet while reset is held, whatever the pre-reset state was.
        if (rst) begin
            iready_out = 1'b0;
            ovalid_out = 1'b0;
            buf_shift  = 1'b0;
            buf_drain  = 1'b0;
        end
    end

    assign busy = ~rst & ((state == S_FILL) | (state == S_RUN) | (state == S_DRAIN));
    assign done = ~rst & (state == S_DONE);

`ifdef OFFBUF_CTRL_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start && (state == S_IDLE || state == S_DONE)) begin
            stall_cnt <= '0;
        end else if (ovalid_out && !oready_in && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + ONE;
        end
    end
`endif

    a_out_le_in: assert property (@(posedge clk) disable iff (rst) out_cnt <= in_cnt);
    a_run_gap: assert property (@(posedge clk) disable iff (rst)
        (state == S_RUN) |-> ((in_cnt - out_cnt) == SIZE_C));
    a_done_cnt: assert property (@(posedge clk) disable iff (rst)
        (state == S_DONE) |-> (out_cnt == NELEM_C));

endmodule

// File: tb/tb_kernel_top_offset_buff_ctrl.sv
// Bench for kernel_top_offset_buff_ctrl: directed vector table, corner sequences and a random run
// checked against a count-based stream model with an environment-side delay line driven by the DUT.
module tb_kernel_top_offset_buff_ctrl;
    localparam int SIZE  = 2;
    localparam int NELEM = 8;
    localparam int CNTW  = 16;
    localparam longint SAT = (64'd1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst, start, ivalid_in, oready_in;
    logic            iready_out, ovalid_out, buf_shift, buf_drain, busy, done;
    logic [CNTW-1:0] in_cnt, out_cnt;
`ifdef OFFBUF_CTRL_STALL_CNT_EN
    logic [CNTW-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    kernel_top_offset_buff_ctrl #(.SIZE(SIZE), .NELEM(NELEM), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ivalid_in  (ivalid_in),
        .iready_out (iready_out),
        .oready_in  (oready_in),
        .ovalid_out (ovalid_out),
        .buf_shift  (buf_shift),
        .buf_drain  (buf_drain),
        .busy       (busy),
        .done       (done),
        .in_cnt     (in_cnt),
        .out_cnt    (out_cnt)
`ifdef OFFBUF_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;

    // Stream model: a stream is active between an honoured start and its NELEM-th emit.
    bit     m_active = 0;
    bit     m_done = 0;
    int     m_in = 0;
    int     m_out = 0;
    longint m_stall = 0;
    int     bufm[SIZE] = '{default: 0};
    int     last_tap = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endfunction

    task automatic apply(input bit r, input bit s, input bit iv, input bit o);
        bit e_ir, e_ov, e_sh, e_dr;
        int din;
        rst = r; start = s; ivalid_in = iv; oready_in = o;
        #2;
        e_ir = 0; e_ov = 0; e_sh = 0; e_dr = 0;
        if (!r && m_active) begin
            if (m_in < SIZE) begin
                e_ir = 1; e_sh = iv;
            end else if (m_in < NELEM) begin
                e_ir = o; e_ov = iv; e_sh = iv & o;
            end else begin
                e_ov = 1; e_sh = o; e_dr = 1;
            end
        end
        chk("iready_out", iready_out, e_ir);
        chk("ovalid_out", ovalid_out, e_ov);
        chk("buf_shift", buf_shift, e_sh);
        chk("buf_drain", buf_drain, e_dr);
        chk("busy", busy, !r && m_active);
        chk("done", done, !r && m_done);
        if (!r) begin
            chk("in_cnt", in_cnt, m_in);
            chk("out_cnt", out_cnt, m_out);
`ifdef OFFBUF_CTRL_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
        end
        last_tap = bufm[SIZE-1];
        if (!r && e_ov && o) chk("tap_data", last_tap, m_out + 1);
        if (r) begin
            m_active = 0; m_done = 0; m_in = 0; m_out = 0; m_stall = 0;
            bufm = '{default: 0};
        end else begin
            // The delay line follows the DUT's own shift/drain controls.
            din = buf_drain ? 0 : m_in + 1;
            if (buf_shift) begin
                for (int i = SIZE - 1; i > 0; i--) bufm[i] = bufm[i-1];
                bufm[0] = din;
            end
            if (e_ov && !o && m_stall != SAT) m_stall++;
            if (!m_active) begin
                if (s) begin
                    m_active = 1; m_done = 0; m_in = 0; m_out = 0; m_stall = 0;
                end
            end else begin
                if (iv && e_ir) m_in++;
                if (e_ov && o) m_out++;
                if (m_out == NELEM) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic cyc(input bit r, input bit s, input bit iv, input bit o);
        apply(r, s, iv, o);
        tick();
    endtask

    task automatic finish_stream(input string name, input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            cyc(0, 0, 1, 1);
            n++;
        end
        if (n >= budget) begin
            fails++;
            tests++;
            $display("FAIL %s: timeout after %0d cycles, expected DONE", name, budget);
        end
        apply(0, 0, 0, 1);
        chk({name, "_done"}, done, 1);
        tick();
    endtask

    typedef struct {
        bit r, s, iv, o;
        bit ir, ov, sh, dr, bz, dn;
        int ic, oc, dat;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int t_start, t_done;
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_start, t_done;
        int guard;
        // r s iv o | ir ov sh dr busy done | in out tap
        tbl[0]  = '{0,0,1,1, 0,0,0,0,0,0, 0,0,0};
        tbl[1]  = '{0,1,0,1, 0,0,0,0,0,0, 0,0,0};
        tbl[2]  = '{0,0,1,1, 1,0,1,0,1,0, 0,0,0};
        tbl[3]  = '{0,0,1,1, 1,0,1,0,1,0, 1,0,0};
        tbl[4]  = '{0,0,1,1, 1,1,1,0,1,0, 2,0,1};
        tbl[5]  = '{0,0,1,1, 1,1,1,0,1,0, 3,1,2};
        tbl[6]  = '{0,0,1,1, 1,1,1,0,1,0, 4,2,3};
        tbl[7]  = '{0,0,1,1, 1,1,1,0,1,0, 5,3,4};
        tbl[8]  = '{0,0,1,1, 1,1,1,0,1,0, 6,4,5};
        tbl[9]  = '{0,0,1,1, 1,1,1,0,1,0, 7,5,6};
        tbl[10] = '{0,0,1,1, 0,1,1,1,1,0, 8,6,7};
        tbl[11] = '{0,0,1,1, 0,1,1,1,1,0, 8,7,8};
        tbl[12] = '{0,0,1,1, 0,0,0,0,0,1, 8,8,0};

        rst = 1; start = 0; ivalid_in = 0; oready_in = 0;
        tick();
        repeat (3) cyc(1, 0, 0, 0);

        // Nominal stream from the table
        t_start = -1; t_done = -1;
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].iv, tbl[i].o);
            chk("tbl_iready", iready_out, tbl[i].ir);
            chk("tbl_ovalid", ovalid_out, tbl[i].ov);
            chk("tbl_shift", buf_shift, tbl[i].sh);
            chk("tbl_drain", buf_drain, tbl[i].dr);
            chk("tbl_busy", busy, tbl[i].bz);
            chk("tbl_done", done, tbl[i].dn);
            chk("tbl_in_cnt", in_cnt, tbl[i].ic);
            chk("tbl_out_cnt", out_cnt, tbl[i].oc);
            if (tbl[i].dat != 0) chk("tbl_tap", last_tap, tbl[i].dat);
            if (tbl[i].s && t_start < 0) t_start = i;
            if (done && t_done < 0) t_done = i;
            tick();
        end
        chk("done_latency", t_done - t_start, 1 + NELEM + SIZE);

        // Downstream backpressure for 3 cycles mid-RUN
        cyc(0, 1, 0, 1);
        guard = 0;
        while (m_in < 4 && guard < 50) begin cyc(0, 0, 1, 1); guard++; end
        repeat (3) cyc(0, 0, 1, 0);
`ifdef OFFBUF_CTRL_STALL_CNT_EN
        apply(0, 0, 1, 1);
        chk("bp_stall_cnt", stall_cnt, 3);
        tick();
`endif
        finish_stream("backpressure", 50);

        // Upstream bubble for 2 cycles in RUN
        cyc(0, 1, 0, 1);
        guard = 0;
        while (m_in < 4 && guard < 50) begin cyc(0, 0, 1, 1); guard++; end
        repeat (2) cyc(0, 0, 0, 1);
        finish_stream("bubble", 50);

        // Drain entered with oready low for 4 cycles, then 2 emits finish the stream
        cyc(0, 1, 0, 1);
        guard = 0;
        while (m_in < NELEM && guard < 50) begin cyc(0, 0, 1, 1); guard++; end
        repeat (4) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        apply(0, 0, 0, 1);
        chk("drain_done_after_2", done, 1);
        tick();

        // Abort at in_cnt==5 (start in same cycle loses to rst), then full restart
        cyc(0, 1, 0, 1);
        guard = 0;
        while (m_in < 5 && guard < 50) begin cyc(0, 0, 1, 1); guard++; end
        cyc(1, 1, 1, 1);
        apply(0, 0, 0, 1);
        chk("abort_busy", busy, 0);
        chk("abort_in_cnt", in_cnt, 0);
        tick();
        cyc(0, 1, 0, 1);
        guard = 0;
        while (m_in < 5 && guard < 50) begin cyc(0, 0, 1, 1); guard++; end
        cyc(0, 1, 1, 1);
        apply(0, 0, 1, 1);
        chk("start_in_run_ignored", in_cnt, 6);
        tick();
        finish_stream("restart", 50);

        // Random handshakes, starts and occasional resets
        for (int k = 0; k < 2000; k++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
